// File: rtl/dcw_pkg.sv
// dcw_pkg: shared op codes, FSM state codes and default clock-field width for the DCW command sequencer
package dcw_pkg;
  localparam int DCW_CLK_W = 25;
  typedef enum logic [1:0] {OP_IDLE = 2'd0, OP_CHRST = 2'd1, OP_CLK = 2'd2, OP_DW = 2'd3} op_e;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;
endpackage

// File: rtl/dcw_cmd_sequencer_if.sv
// dcw_cmd_sequencer_if: host req_* handshake, DCW control bus and status; master = host/DCW side (drives req_*, channel_reset), slave = sequencer
interface dcw_cmd_sequencer_if #(parameter int CLK_W = dcw_pkg::DCW_CLK_W);
  logic req_valid, req_ready;
  logic [1:0] req_op;
  logic [2:0] req_val, req_val1;
  logic [CLK_W-1:0] req_clk;
  logic [2:0] ctrl_sig, val, val1;
  logic [CLK_W-1:0] wanted_cl_val, earlier_cl_val;
  logic channel_reset, busy, done, err;
  modport master (
    output req_valid, req_op, req_val, req_val1, req_clk, channel_reset,
    input req_ready, ctrl_sig, val, val1, wanted_cl_val, earlier_cl_val, busy, done, err
  );
  modport slave (
    input req_valid, req_op, req_val, req_val1, req_clk, channel_reset,
    output req_ready, ctrl_sig, val, val1, wanted_cl_val, earlier_cl_val, busy, done, err
  );
endinterface

// File: rtl/dcw_edge_ack.sv
// dcw_edge_ack: while armed, flags a channel_reset rise-then-fall (ack) or ACK_TIMEOUT armed cycles without one (timeout); ports clock, reset, arm, channel_reset -> ack, timeout
module dcw_edge_ack #(
  parameter int ACK_TIMEOUT = 16,
  parameter int CW = 5
) (
  input logic clock,
  input logic reset,
  input logic arm,
  input logic channel_reset,
  output logic ack,
  output logic timeout
);
  logic cr_q, seen_q;
  logic [CW-1:0] tcnt_q;
  assign ack = arm && seen_q && cr_q && !channel_reset;
  assign timeout = arm && !ack && tcnt_q == CW'(ACK_TIMEOUT - 1);
  always_ff @(posedge clock)
    if (reset) begin
      cr_q <= 1'b0;
      seen_q <= 1'b0;
      tcnt_q <= '0;
    end else begin
      cr_q <= channel_reset;
      seen_q <= arm && (seen_q || (channel_reset && !cr_q));
      tcnt_q <= arm ? tcnt_q + CW'(tcnt_q != '1) : '0;
    end
endmodule

// File: rtl/dcw_cmd_sequencer.sv
// dcw_cmd_sequencer: accepts one host command (bus.req_*), drives the DCW control bus for HOLD_CYCLES, waits ack/settle, pulses done/err; ports clock, reset, bus (slave)
module dcw_cmd_sequencer
  import dcw_pkg::*;
#(
  parameter int CLK_W = DCW_CLK_W,
  parameter int HOLD_CYCLES = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int DEFAULT_CLK = 20000000
) (
  input logic clock,
  input logic reset,
  dcw_cmd_sequencer_if.slave bus
);
  localparam int MAX_HS = HOLD_CYCLES > SETTLE_CYCLES ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(MAX_HS > ACK_TIMEOUT ? MAX_HS : ACK_TIMEOUT) + 1;
  localparam logic [CLK_W-1:0] DEF = CLK_W'(DEFAULT_CLK);
  logic [1:0] state_q, state_d, op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] ctrl_q, ctrl_d, val_q, val_d, val1_q, val1_d;
  logic [CLK_W-1:0] want_q, want_d, earl_q, earl_d;
  logic done_q, done_d, err_q, err_d, ack, timeout;
  dcw_edge_ack #(.ACK_TIMEOUT(ACK_TIMEOUT), .CW(CW)) u_ack (
    .clock(clock),
    .reset(reset),
    .arm(state_q == ST_WAIT_ACK),
    .channel_reset(bus.channel_reset),
    .ack(ack),
    .timeout(timeout)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q + CW'(cnt_q != '1);
    ctrl_d = ctrl_q;
    val_d = val_q;
    val1_d = val1_q;
    want_d = want_q;
    earl_d = earl_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      ST_IDLE:
        if (bus.req_valid) begin
          if (bus.req_op == OP_IDLE || (bus.req_op == OP_CLK && bus.req_clk == '0)) err_d = 1'b1;
          else if (bus.req_op == OP_CLK && bus.req_clk == earl_q) done_d = 1'b1;
          else begin
            state_d = ST_DRIVE;
            op_d = bus.req_op;
            cnt_d = '0;
            ctrl_d = {1'b0, bus.req_op};
            val_d = bus.req_val;
            val1_d = bus.req_val1;
            want_d = bus.req_op == OP_CLK ? bus.req_clk : earl_q;
          end
        end
      ST_DRIVE:
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = op_q == OP_CHRST ? ST_WAIT_ACK : ST_SETTLE;
          cnt_d = '0;
          ctrl_d = '0;
        end
      ST_WAIT_ACK:
        if (ack) begin
          state_d = ST_SETTLE;
          cnt_d = '0;
        end else if (timeout) begin
          state_d = ST_IDLE;
          err_d = 1'b1;
        end
      default:
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = ST_IDLE;
          done_d = 1'b1;
          earl_d = op_q == OP_CLK ? want_q : earl_q;
        end
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= ST_IDLE;
      op_q <= '0;
      cnt_q <= '0;
      ctrl_q <= '0;
      val_q <= '0;
      val1_q <= '0;
      want_q <= DEF;
      earl_q <= DEF;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      ctrl_q <= ctrl_d;
      val_q <= val_d;
      val1_q <= val1_d;
      want_q <= want_d;
      earl_q <= earl_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign bus.req_ready = state_q == ST_IDLE;
  assign bus.busy = state_q != ST_IDLE;
  assign bus.ctrl_sig = ctrl_q;
  assign bus.val = val_q;
  assign bus.val1 = val1_q;
  assign bus.wanted_cl_val = want_q;
  assign bus.earlier_cl_val = earl_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_dcw_cmd_sequencer.sv
// tb_dcw_cmd_sequencer: randomized scoreboard bench for dcw_cmd_sequencer against a cycle-level reference of the command rules
module tb_dcw_cmd_sequencer;
  localparam int CLK_W = 25;
  localparam int H = 4;
  localparam int S = 8;
  localparam int T = 16;
  localparam logic [CLK_W-1:0] DEF = 25'd20000000;
  typedef struct {
    bit is_err;
    int cyc;
    logic [CLK_W-1:0] earl;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  exp_t q[$];
  logic [CLK_W-1:0] cur_clk = DEF;
  logic [CLK_W-1:0] exp_earl = DEF;
  int win_lo = 0;
  int win_hi = -1;
  logic [2:0] win_op = '0, win_v = '0, win_v1 = '0;
  logic [CLK_W-1:0] win_clk = '0;
  dcw_cmd_sequencer_if #(.CLK_W(CLK_W)) dut_if ();
  dcw_cmd_sequencer #(
    .CLK_W(CLK_W), .HOLD_CYCLES(H), .SETTLE_CYCLES(S), .ACK_TIMEOUT(T), .DEFAULT_CLK(20000000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(dut_if)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clock) if (mon_en) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missed_resp: nothing at cycle %0d, expected %s", q[0].cyc, q[0].is_err ? "err" : "done");
      q.delete(0);
    end
    if (dut_if.done || dut_if.err) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp at cycle %0d: done=%0b err=%0b, expected none", cyc, dut_if.done, dut_if.err);
      end else begin
        e = q.pop_front();
        chk("resp_err", 64'(dut_if.err), 64'(e.is_err));
        chk("resp_done", 64'(dut_if.done), 64'(!e.is_err));
        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
        exp_earl = e.earl;
      end
    end
    chk("ctrl_sig", 64'(dut_if.ctrl_sig), 64'((cyc >= win_lo && cyc <= win_hi) ? win_op : 3'd0));
    chk("earlier_cl_val", 64'(dut_if.earlier_cl_val), 64'(exp_earl));
    if (cyc >= win_lo && cyc <= win_hi) begin
      chk("val", 64'(dut_if.val), 64'(win_v));
      chk("val1", 64'(dut_if.val1), 64'(win_v1));
      chk("wanted_cl_val", 64'(dut_if.wanted_cl_val), 64'(win_clk));
    end
  end
  task automatic issue(input logic [1:0] op, input logic [2:0] v, input logic [2:0] v1,
                       input logic [CLK_W-1:0] c, input int d, input int w, output int t);
    exp_t e;
    int ws, n;
    @(posedge clock);
    #1;
    dut_if.req_valid = 1'b1;
    dut_if.req_op = op;
    dut_if.req_val = v;
    dut_if.req_val1 = v1;
    dut_if.req_clk = c;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!dut_if.req_ready && n < 200);
    if (!dut_if.req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_wait: req_ready still 0 after %0d cycles, expected 1", n);
      dut_if.req_valid = 1'b0;
      t = -1;
      return;
    end
    t = cyc;
    ws = t + H + 1;
    if (op == 2'd0 || (op == 2'd2 && c == '0)) e = '{is_err: 1'b1, cyc: t + 1, earl: cur_clk};
    else if (op == 2'd2 && c == cur_clk) e = '{is_err: 1'b0, cyc: t + 1, earl: cur_clk};
    else begin
      win_lo = t + 1;
      win_hi = t + H;
      win_op = {1'b0, op};
      win_v = v;
      win_v1 = v1;
      win_clk = op == 2'd2 ? c : cur_clk;
      if (op == 2'd2) begin
        e = '{is_err: 1'b0, cyc: t + 1 + H + S, earl: c};
        cur_clk = c;
      end else if (op == 2'd3) e = '{is_err: 1'b0, cyc: t + 1 + H + S, earl: cur_clk};
      else if (w > 0 && d >= 0 && d + w <= T - 1) e = '{is_err: 1'b0, cyc: ws + d + w + 1 + S, earl: cur_clk};
      else e = '{is_err: 1'b1, cyc: ws + T, earl: cur_clk};
    end
    q.push_back(e);
    @(posedge clock);
    #1;
    dut_if.req_valid = 1'b0;
    if (op == 2'd1 && w > 0)
      while (1) begin
        dut_if.channel_reset = cyc >= ws + d && cyc < ws + d + w;
        if (cyc >= ws + d + w) break;
        @(posedge clock);
        #1;
      end
  endtask
  initial begin
    int t, t2;
    logic [1:0] op;
    logic [CLK_W-1:0] c;
    int d, w, m;
    dut_if.req_valid = 1'b0;
    dut_if.req_op = '0;
    dut_if.req_val = '0;
    dut_if.req_val1 = '0;
    dut_if.req_clk = '0;
    dut_if.channel_reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", 64'(dut_if.req_ready), 64'd1);
    chk("rst_busy", 64'(dut_if.busy), 64'd0);
    chk("rst_ctrl_sig", 64'(dut_if.ctrl_sig), 64'd0);
    chk("rst_val", 64'(dut_if.val), 64'd0);
    chk("rst_val1", 64'(dut_if.val1), 64'd0);
    chk("rst_wanted", 64'(dut_if.wanted_cl_val), 64'(DEF));
    chk("rst_earlier", 64'(dut_if.earlier_cl_val), 64'(DEF));
    chk("rst_done", 64'(dut_if.done), 64'd0);
    chk("rst_err", 64'(dut_if.err), 64'd0);
    mon_en = 1'b1;
    issue(2'd2, 3'd0, 3'd0, DEF, 0, 0, t);
    issue(2'd2, 3'd1, 3'd2, 25'd0, 0, 0, t);
    issue(2'd3, 3'd7, 3'd5, 25'd0, 0, 0, t);
    issue(2'd2, 3'd3, 3'd4, 25'd10000000, 0, 0, t);
    issue(2'd1, 3'd2, 3'd6, 25'd0, 3, 2, t);
    issue(2'd1, 3'd1, 3'd1, 25'd0, 0, 0, t);
    issue(2'd1, 3'd5, 3'd2, 25'd0, 13, 2, t);
    issue(2'd1, 3'd5, 3'd3, 25'd0, 14, 2, t);
    issue(2'd1, 3'd4, 3'd4, 25'd0, -1, 3, t);
    issue(2'd0, 3'd7, 3'd7, 25'd123, 0, 0, t);
    issue(2'd3, 3'd6, 3'd1, 25'd0, 0, 0, t);
    issue(2'd2, 3'd0, 3'd7, 25'd7777777, 0, 0, t2);
    chk("held_accept_cycle", 64'(t2), 64'(t + 1 + H + S));
    issue(2'd2, 3'd2, 3'd2, 25'd5000000, 0, 0, t);
    @(posedge clock);
    #1;
    reset = 1'b1;
    win_hi = cyc;
    q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_earl = DEF;
    cur_clk = DEF;
    @(negedge clock);
    chk("midrst_ctrl_sig", 64'(dut_if.ctrl_sig), 64'd0);
    chk("midrst_earlier", 64'(dut_if.earlier_cl_val), 64'(DEF));
    chk("midrst_req_ready", 64'(dut_if.req_ready), 64'd1);
    chk("midrst_done", 64'(dut_if.done), 64'd0);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      op = 2'($urandom_range(0, 3));
      m = int'($urandom_range(0, 3));
      c = m == 0 ? 25'd0 : m == 1 ? cur_clk : 25'($urandom_range(1, 33554431));
      d = int'($urandom_range(0, 10));
      w = int'($urandom_range(1, 4));
      if (op == 2'd1 && m == 2) w = 0;
      if (op == 2'd1 && m == 3) begin
        d = -1;
        w = 3;
      end
      issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), c, d, w, t);
    end
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d responses still pending, expected 0", q.size());
    end
    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
